// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared definitions for the parametrised synchronous FIFO:
//             default geometry, count/pointer width helpers and the
//             parameter legality check used at elaboration.
//  Ports    : (package - none)
//  Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1 states.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointers address DEPTH entries and wrap naturally at the power of two.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit params_legal(input int unsigned width,
                                      input int unsigned depth,
                                      input int unsigned af,
                                      input int unsigned ae);
    return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) && (ae < depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem_2p.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_mem_2p
//  Purpose  : DEPTH x WIDTH storage, one synchronous write port and one
//             synchronous (registered) read port. The read register is
//             reset to zero; the array itself is never cleared.
//  Ports    : clock, reset          - clock / synchronous active-high reset
//             wr_en_i, wr_addr_i,
//             wr_data_i             - write port
//             rd_en_i, rd_addr_i    - read request / address
//             rd_data_o             - registered read data, holds when idle
//  Revision : 1.0  initial release
// ============================================================================
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en_i,
  input  logic [ptr_width(DEPTH)-1:0]   wr_addr_i,
  input  logic [WIDTH-1:0]              wr_data_i,
  input  logic                          rd_en_i,
  input  logic [ptr_width(DEPTH)-1:0]   rd_addr_i,
  output logic [WIDTH-1:0]              rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read samples the array before this edge's write lands, so a read and
  // write to the same slot (full FIFO) returns the old word.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param
//  Purpose  : Parametrised single-clock FIFO with occupancy count,
//             almost-full/almost-empty thresholds, registered read data with
//             valid strobe and sticky overflow/underflow error flags.
//  Ports    : clock, reset          - clock / synchronous active-high reset
//             write_en, data_in     - write request and data
//             read_en               - read request
//             data_out, data_valid  - registered read data + 1-cycle strobe
//             fifo_full, fifo_empty,
//             almost_full,
//             almost_empty, count   - registered occupancy status
//             overflow_err,
//             underflow_err         - sticky rejected-request flags
//             clear_err             - clears both error flags
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         write_en,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         read_en,
  output logic [WIDTH-1:0]             data_out,
  output logic                         data_valid,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         overflow_err,
  output logic                         underflow_err,
  input  logic                         clear_err
);

  localparam int unsigned c_cnt_w = cnt_width(DEPTH);
  localparam int unsigned c_ptr_w = ptr_width(DEPTH);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_af    = c_cnt_w'(AF_THRESH);
  localparam logic [c_cnt_w-1:0] c_ae    = c_cnt_w'(AE_THRESH);

  if (!params_legal(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_check
    $error("sync_fifo_param: illegal WIDTH/DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q,  count_d;
  logic               full_q,   full_d;
  logic               empty_q,  empty_d;
  logic               afull_q,  afull_d;
  logic               aempty_q, aempty_d;
  logic               valid_q,  valid_d;
  logic               ovf_q,    ovf_d;
  logic               unf_q,    unf_d;
  logic               rd_ok;
  logic               wr_ok;

  // At full, an accepted read frees a slot in the same cycle, so the write
  // is allowed too. At empty the read is rejected (no fall-through).
  assign rd_ok = read_en & ~empty_q;
  assign wr_ok = write_en & (~full_q | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ok ? (wr_ptr_q + c_ptr_w'(1)) : wr_ptr_q;
    rd_ptr_d = rd_ok ? (rd_ptr_q + c_ptr_w'(1)) : rd_ptr_q;
    count_d  = count_q + c_cnt_w'(wr_ok) - c_cnt_w'(rd_ok);
    // Flags come from the next count so they are exact one cycle after
    // the event that changed occupancy.
    full_d   = (count_d == c_depth);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= c_af);
    aempty_d = (count_d <= c_ae);
    valid_d  = rd_ok;
    // Set has priority over clear.
    ovf_d    = (write_en & ~wr_ok) | (ovf_q & ~clear_err);
    unf_d    = (read_en  & ~rd_ok) | (unf_q & ~clear_err);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (wr_ok & ~reset),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (rd_ok),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

  assign data_valid    = valid_q;
  assign fifo_full     = full_q;
  assign fifo_empty    = empty_q;
  assign almost_full   = afull_q;
  assign almost_empty  = aempty_q;
  assign count         = count_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_param
//  Purpose  : Self-checking bench for sync_fifo_param (8 x 16, AF=14, AE=2)
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_param;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_valid, fifo_full, fifo_empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow_err, underflow_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  sync_fifo_param #(
    .WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clock(clock), .reset(reset), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .data_out(data_out), .data_valid(data_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow_err(overflow_err),
    .underflow_err(underflow_err), .clear_err(clear_err)
  );

  always #5 clock = ~clock;

  // Drive one cycle of requests, advance the model with the FIFO rules,
  // and return 1 ns after the edge so outputs can be sampled.
  task automatic step(input bit we, input logic [7:0] din, input bit re, input bit clr);
    bit rd, wr;
    write_en  = we;
    data_in   = din;
    read_en   = re;
    clear_err = clr;
    rd = re && (q.size() != 0);
    wr = we && ((q.size() < DEPTH) || rd);
    @(posedge clock);
    m_valid = rd;
    if (rd) m_dout = q.pop_front();
    if (wr) q.push_back(din);
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (we && !wr) m_ovf = 1'b1;
    if (re && !rd) m_unf = 1'b1;
    #1;
    write_en = 1'b0; read_en = 1'b0; clear_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    m_dout = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0 || fifo_empty !== 1'b1 || almost_empty !== 1'b1 ||
        fifo_full !== 1'b0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: count=%0d empty=%b ae=%b full=%b af=%b, required 0 1 1 0 0",
               count, fifo_empty, almost_empty, fifo_full, almost_full);
    end
    checks++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: dout=%h valid=%b ovf=%b unf=%b, required 00 0 0 0",
               data_out, data_valid, overflow_err, underflow_err);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      checks++;
      if (count !== 5'(i) || almost_full !== (i >= AF) || fifo_full !== (i == DEPTH) ||
          fifo_empty !== 1'b0 || almost_empty !== (i <= AE)) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d af=%b full=%b empty=%b ae=%b, required %0d %b %b 0 %b",
                 i, count, almost_full, fifo_full, fifo_empty, almost_empty,
                 i, (i >= AF), (i == DEPTH), (i <= AE));
      end
    end
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++;
    if (overflow_err !== 1'b1 || count !== 5'd16 || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL overflow: ovf=%b count=%0d full=%b, required 1 16 1",
               overflow_err, count, fifo_full);
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (data_out !== 8'(i) || data_valid !== 1'b1 || count !== 5'(16 - i) ||
          fifo_empty !== (i == 16) || almost_empty !== ((16 - i) <= AE) ||
          almost_full !== ((16 - i) >= AF) || fifo_full !== 1'b0) begin
        errors++;
        $display("FAIL drain_%0d: dout=%h valid=%b count=%0d empty=%b ae=%b af=%b full=%b, required %h 1 %0d",
                 i, data_out, data_valid, count, fifo_empty, almost_empty, almost_full, fifo_full,
                 8'(i), 16 - i);
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (underflow_err !== 1'b1 || data_out !== 8'h10 || data_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL underflow: unf=%b dout=%h valid=%b count=%0d, required 1 10 0 0",
               underflow_err, data_out, data_valid, count);
    end
  endtask

  task automatic test_full_rw();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL clear_before_full_rw: ovf=%b unf=%b, required 0 0", overflow_err, underflow_err);
    end
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd16 || fifo_full !== 1'b1 || overflow_err !== 1'b0 ||
        data_valid !== 1'b1 || data_out !== 8'h21) begin
      errors++;
      $display("FAIL full_rw: count=%0d full=%b ovf=%b valid=%b dout=%h, required 16 1 0 1 21",
               count, fifo_full, overflow_err, data_valid, data_out);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (data_out !== m_dout || data_valid !== 1'b1) begin
        errors++;
        $display("FAIL full_rw_read_%0d: dout=%h valid=%b, required %h 1", i, data_out, data_valid, m_dout);
      end
    end
    checks++;
    if (data_out !== 8'h55 || count !== 5'd0) begin
      errors++;
      $display("FAIL full_rw_last: dout=%h count=%0d, required 55 0", data_out, count);
    end
  endtask

  task automatic test_empty_rw_clear();
    step(1'b1, 8'h77, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd1 || underflow_err !== 1'b1 || data_valid !== 1'b0 || fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw: count=%0d unf=%b valid=%b empty=%b, required 1 1 0 0",
               count, underflow_err, data_valid, fifo_empty);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL clear_err: ovf=%b unf=%b, required 0 0", overflow_err, underflow_err);
    end
    // Set wins over a simultaneous clear.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h77 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL empty_rw_read: dout=%h valid=%b, required 77 1", data_out, data_valid);
    end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (underflow_err !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear: unf=%b, required 1", underflow_err);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random_wrap();
    int  nwr;
    int  guard;
    bit  we, re;
    nwr = 0;
    guard = 0;
    while (nwr < 40 && guard < 2000) begin
      we = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 2) == 0) || (q.size() > 12);
      if (we && ((q.size() < DEPTH) || (re && q.size() != 0))) nwr++;
      step(we, 8'($urandom), re, 1'b0);
      guard++;
      checks++;
      if (data_valid !== m_valid || (m_valid && data_out !== m_dout) || data_out !== m_dout ||
          count !== 5'(q.size()) || fifo_empty !== (q.size() == 0) ||
          fifo_full !== (q.size() == DEPTH) || almost_full !== (q.size() >= AF) ||
          almost_empty !== (q.size() <= AE) || overflow_err !== m_ovf || underflow_err !== m_unf) begin
        errors++;
        $display("FAIL random_%0d: dout=%h valid=%b count=%0d full=%b empty=%b af=%b ae=%b ovf=%b unf=%b, required dout=%h valid=%b count=%0d ovf=%b unf=%b",
                 guard, data_out, data_valid, count, fifo_full, fifo_empty, almost_full,
                 almost_empty, overflow_err, underflow_err, m_dout, m_valid, q.size(), m_ovf, m_unf);
      end
    end
    checks++;
    if (nwr < 40) begin
      errors++;
      $display("FAIL random_budget: writes=%0d, required 40", nwr);
    end
    // Bring occupancy to exactly 5, then reset mid-operation.
    while (q.size() > 5) step(1'b0, 8'h00, 1'b1, 1'b0);
    while (q.size() < 5) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    checks++;
    if (count !== 5'd5) begin
      errors++;
      $display("FAIL pre_reset_count: count=%0d, required 5", count);
    end
    do_reset();
    checks++;
    if (count !== 5'd0 || fifo_empty !== 1'b1 || data_valid !== 1'b0 ||
        overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d empty=%b valid=%b ovf=%b unf=%b, required 0 1 0 0 0",
               count, fifo_empty, data_valid, overflow_err, underflow_err);
    end
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h3C || data_valid !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_read: dout=%h valid=%b count=%0d, required 3c 1 0",
               data_out, data_valid, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_full_rw();
    test_empty_rw_clear();
    test_random_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
